// File: rtl/filter_pkg.sv
// filter_pkg: shared constants, state type and
// weight index decode for the filter bank loader.
package filter_pkg;

  localparam int K_ROWS    = 3;
  localparam int K_COLS    = 3;
  localparam int K_CH      = 3;
  localparam int K_WEIGHTS = 27;
  localparam int NUM_BANKS = 4;
  localparam int IDX_W     = 5;

  typedef enum logic {
    IDLE,
    LOAD
  } loader_state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] ch;
  } weight_pos_t;

  // Channel outermost, column fastest.
  function automatic weight_pos_t weight_pos(
    input logic [IDX_W-1:0] n
  );
    weight_pos_t      p;
    logic [IDX_W-1:0] r;
    r     = n % IDX_W'(K_ROWS * K_COLS);
    p.ch  = 2'(n / IDX_W'(K_ROWS * K_COLS));
    p.row = 2'(r / IDX_W'(K_COLS));
    p.col = 2'(r % IDX_W'(K_COLS));
    return p;
  endfunction

endpackage

// File: rtl/filter_weight_index.sv
// filter_weight_index: 0..26 weight counter with
// last flag and decoded (row, col, channel).
module filter_weight_index
  import filter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic        last,
  output weight_pos_t pos
);

  logic [IDX_W-1:0] idx;

  // Counter: clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == IDX_W'(K_WEIGHTS - 1));
  assign pos  = weight_pos(idx);

endmodule

// File: rtl/filter_bank_loader.sv
// filter_bank_loader: streams 27 weights into a shadow
// buffer and commits one 3x3x3 bank atomically.
module filter_bank_loader
  import filter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_start,
  input  logic [1:0]                      load_bank,
  input  logic                            abort,
  input  logic                            s_valid,
  input  logic [WIDTH-1:0]                s_data,
  output logic                            s_ready,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_BANKS-1:0]            bank_valid,
  output logic [2:0][2:0][2:0][WIDTH-1:0] filter_bank0,
  output logic [2:0][2:0][2:0][WIDTH-1:0] filter_bank1,
  output logic [2:0][2:0][2:0][WIDTH-1:0] filter_bank2,
  output logic [2:0][2:0][2:0][WIDTH-1:0] filter_bank3
);

  typedef logic [K_ROWS-1:0][K_COLS-1:0]
                [K_CH-1:0][WIDTH-1:0] filt_t;

  loader_state_t        state;
  logic [1:0]           bank_sel;
  logic                 done_q;
  logic [NUM_BANKS-1:0] valid_q;
  filt_t                shadow;
  filt_t                commit_val;
  filt_t                bank_q [NUM_BANKS];

  logic        in_load;
  logic        start;
  logic        accept;
  logic        commit;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        last;
  weight_pos_t pos;

  assign in_load = (state == LOAD);
  assign start   = !in_load && load_start;
  assign accept  = in_load && !abort && s_valid;
  assign commit  = accept && last;
  assign cnt_clr = start || (in_load && abort) || commit;
  assign cnt_inc = accept && !last;

  filter_weight_index u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .last  (last),
    .pos   (pos)
  );

  // Final weight bypasses the shadow into the commit image.
  always_comb begin
    commit_val = shadow;
    commit_val[K_ROWS-1][K_COLS-1][K_CH-1] = s_data;
  end

  // Load FSM, shadow fill and atomic bank commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bank_sel <= '0;
      done_q   <= 1'b0;
      valid_q  <= '0;
      shadow   <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_q[b] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_start) begin
            bank_sel <= load_bank;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else if (commit) begin
            bank_q[bank_sel]  <= commit_val;
            valid_q[bank_sel] <= 1'b1;
            done_q            <= 1'b1;
            state             <= IDLE;
          end else if (accept) begin
            shadow[pos.row][pos.col][pos.ch] <= s_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_ready      = in_load;
  assign busy         = in_load;
  assign done         = done_q;
  assign bank_valid   = valid_q;
  assign filter_bank0 = bank_q[0];
  assign filter_bank1 = bank_q[1];
  assign filter_bank2 = bank_q[2];
  assign filter_bank3 = bank_q[3];

endmodule

// File: tb/tb_filter_bank_loader.sv
// tb_filter_bank_loader: directed checks of load,
// gapped stream, abort, ignored start and reset.
module tb_filter_bank_loader;

  typedef logic [2:0][2:0][2:0][7:0] filt_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load_start = 1'b0;
  logic [1:0] load_bank = 2'd0;
  logic       abort = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_ready;
  logic       busy;
  logic       done;
  logic [3:0] bank_valid;
  filt_t      fb0;
  filt_t      fb1;
  filt_t      fb2;
  filt_t      fb3;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  filter_bank_loader #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .load_bank    (load_bank),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .busy         (busy),
    .done         (done),
    .bank_valid   (bank_valid),
    .filter_bank0 (fb0),
    .filter_bank1 (fb1),
    .filter_bank2 (fb2),
    .filter_bank3 (fb3)
  );

  task automatic chk(
    input string        tag,
    input logic [215:0] obs,
    input logic [215:0] exp
  );
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Weight n = base + step*n placed at [row][col][ch].
  function automatic filt_t exp_filter(
    input logic [7:0] base,
    input logic [7:0] step
  );
    filt_t f;
    f = '0;
    for (int n = 0; n < 27; n++) begin
      f[(n % 9) / 3][n % 3][n / 9] = 8'(base + step * n);
    end
    return f;
  endfunction

  task automatic start_load(input logic [1:0] b);
    load_start = 1'b1;
    load_bank  = b;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Push weights; idle 'gap' cycles between them.
  task automatic push(
    input int         first,
    input int         count,
    input logic [7:0] base,
    input logic [7:0] step,
    input int         gap
  );
    for (int n = first; n < first + count; n++) begin
      s_valid = 1'b1;
      s_data  = 8'(base + step * n);
      @(negedge clk);
      s_valid = 1'b0;
      if (n != first + count - 1) begin
        repeat (gap) @(negedge clk);
      end
    end
  endtask

  initial begin
    // Asynchronous reset in mid-cycle.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_fb0", 216'(fb0), 216'(0));
    chk("rst_fb1", 216'(fb1), 216'(0));
    chk("rst_fb2", 216'(fb2), 216'(0));
    chk("rst_fb3", 216'(fb3), 216'(0));
    chk("rst_valid", 216'(bank_valid), 216'(0));
    chk("rst_ready", 216'(s_ready), 216'(0));
    chk("rst_busy", 216'(busy), 216'(0));
    chk("rst_done", 216'(done), 216'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Bank 2, continuous stream 1..27.
    start_load(2'd2);
    push(0, 26, 8'd1, 8'd1, 0);
    chk("b2_pre_done", 216'(done), 216'(0));
    chk("b2_busy", 216'(busy), 216'(1));
    chk("b2_ready", 216'(s_ready), 216'(1));
    chk("b2_pre_fb2", 216'(fb2), 216'(0));
    push(26, 1, 8'd1, 8'd1, 0);
    chk("b2_done28", 216'(done), 216'(1));
    chk("b2_idle_busy", 216'(busy), 216'(0));
    chk("b2_idle_ready", 216'(s_ready), 216'(0));
    chk("b2_000", 216'(fb2[0][0][0]), 216'(1));
    chk("b2_010", 216'(fb2[0][1][0]), 216'(2));
    chk("b2_100", 216'(fb2[1][0][0]), 216'(4));
    chk("b2_001", 216'(fb2[0][0][1]), 216'(10));
    chk("b2_222", 216'(fb2[2][2][2]), 216'(27));
    chk("b2_full", 216'(fb2),
        216'(exp_filter(8'd1, 8'd1)));
    chk("b2_fb0", 216'(fb0), 216'(0));
    chk("b2_fb1", 216'(fb1), 216'(0));
    chk("b2_fb3", 216'(fb3), 216'(0));
    chk("b2_valid", 216'(bank_valid), 216'(4'b0100));
    @(negedge clk);
    chk("b2_done_1cyc", 216'(done), 216'(0));

    // Bank 0, s_valid pattern 1,0,0,1,...
    start_load(2'd0);
    push(0, 26, 8'd1, 8'd1, 2);
    repeat (2) @(negedge clk);
    chk("b0_hold_fb0", 216'(fb0), 216'(0));
    chk("b0_hold_done", 216'(done), 216'(0));
    chk("b0_hold_busy", 216'(busy), 216'(1));
    push(26, 1, 8'd1, 8'd1, 0);
    chk("b0_done", 216'(done), 216'(1));
    chk("b0_full", 216'(fb0),
        216'(exp_filter(8'd1, 8'd1)));
    chk("b0_001", 216'(fb0[0][0][1]), 216'(10));
    chk("b0_valid", 216'(bank_valid), 216'(4'b0101));
    @(negedge clk);

    // Bank 1 preload all AA.
    start_load(2'd1);
    push(0, 27, 8'hAA, 8'd0, 0);
    chk("b1_pre_done", 216'(done), 216'(1));
    chk("b1_pre_full", 216'(fb1),
        216'(exp_filter(8'hAA, 8'd0)));
    chk("b1_pre_valid", 216'(bank_valid), 216'(4'b0111));
    @(negedge clk);

    // Reload bank 1, abort after 10 weights.
    start_load(2'd1);
    push(0, 10, 8'h11, 8'd1, 0);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h55;
    @(negedge clk);
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("ab_ready", 216'(s_ready), 216'(0));
    chk("ab_busy", 216'(busy), 216'(0));
    chk("ab_done", 216'(done), 216'(0));
    chk("ab_fb1", 216'(fb1),
        216'(exp_filter(8'hAA, 8'd0)));
    chk("ab_valid", 216'(bank_valid), 216'(4'b0111));
    @(negedge clk);
    chk("ab_done2", 216'(done), 216'(0));

    // Abort coincides with final handshake.
    start_load(2'd1);
    push(0, 26, 8'h11, 8'd1, 0);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h2B;
    @(negedge clk);
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("abl_done", 216'(done), 216'(0));
    chk("abl_ready", 216'(s_ready), 216'(0));
    chk("abl_fb1", 216'(fb1),
        216'(exp_filter(8'hAA, 8'd0)));

    // Abort in IDLE has no effect.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abi_ready", 216'(s_ready), 216'(0));
    chk("abi_valid", 216'(bank_valid), 216'(4'b0111));

    // Bank 0 reload with stray load_start to bank 3.
    start_load(2'd0);
    push(0, 5, 8'h80, 8'd1, 0);
    load_start = 1'b1;
    load_bank  = 2'd3;
    push(5, 1, 8'h80, 8'd1, 0);
    load_start = 1'b0;
    push(6, 21, 8'h80, 8'd1, 0);
    chk("ls_done", 216'(done), 216'(1));
    chk("ls_fb0", 216'(fb0),
        216'(exp_filter(8'h80, 8'd1)));
    chk("ls_fb3", 216'(fb3), 216'(0));
    chk("ls_fb2", 216'(fb2),
        216'(exp_filter(8'd1, 8'd1)));
    chk("ls_valid", 216'(bank_valid), 216'(4'b0111));
    @(negedge clk);

    // Reset during a bank 2 reload.
    start_load(2'd2);
    push(0, 15, 8'h40, 8'd1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_fb0", 216'(fb0), 216'(0));
    chk("mr_fb1", 216'(fb1), 216'(0));
    chk("mr_fb2", 216'(fb2), 216'(0));
    chk("mr_fb3", 216'(fb3), 216'(0));
    chk("mr_valid", 216'(bank_valid), 216'(0));
    chk("mr_busy", 216'(busy), 216'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_idle_ready", 216'(s_ready), 216'(0));
    chk("mr_idle_done", 216'(done), 216'(0));

    // Fresh full load after reset.
    start_load(2'd2);
    push(0, 27, 8'd1, 8'd1, 0);
    chk("rl_done", 216'(done), 216'(1));
    chk("rl_fb2", 216'(fb2),
        216'(exp_filter(8'd1, 8'd1)));
    chk("rl_valid", 216'(bank_valid), 216'(4'b0100));
    chk("rl_fb0", 216'(fb0), 216'(0));
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
